// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges the core memory port to the banked system bus.
// One request in flight at a time. Alignment and bank mapping are checked at
// accept time; legal requests go out as a word-aligned, byte-enabled bus
// access, and the read data comes back lane-aligned and sign/zero-extended.
//
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN
//   When defined, the bus wait is limited to TIMEOUT_CYCLES.
//   If the limit is reached, the response reports exception bit 2.
//
// Handshakes:
//   Core side: a request transfers on a rising edge where req_valid and
//   req_ready are both high. Request fields are sampled only on that edge.
//   The core holds req_valid until it is accepted.
//   Bus side: bus_req stays high, with every bus output held constant, until
//   the edge where bus_ack is high. That edge completes the transfer.
//   bus_ack is ignored whenever bus_req is low.
module mem_access_unit #(
  parameter logic [15:0] VALID_BANKS    = 16'h0007,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  input  logic        req_wr_ena,
  input  logic [1:0]  req_access,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rd_data,
  output logic [2:0]  resp_exception,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_wr_ena,
  output logic [3:0]  bus_byte_ena,
  output logic [31:0] bus_wr_data,
  input  logic        bus_ack,
  input  logic [31:0] bus_rd_data,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Access size encoding: 0 byte, 1 half, 2 word (3 is treated as word).
  localparam logic [1:0] ACC_BYTE = 2'd0;
  localparam logic [1:0] ACC_HALF = 2'd1;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [1:0]  acc_q;
  logic        uns_q;
  logic [31:0] result_q;
  logic [2:0]  exc_q;

  logic [2:0]  req_exc;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        timeout;

  // Exception mask computed from the live request fields.
  always_comb begin
    req_exc    = 3'b000;
    req_exc[0] = ((req_access == ACC_HALF) && req_addr[0]) ||
                 (req_access[1] && (req_addr[1:0] != 2'b00));
    req_exc[1] = ~VALID_BANKS[req_addr[31:28]];
  end

  // Move the addressed lane down to bit 0 and extend it to 32 bits.
  always_comb begin
    rd_shift = bus_rd_data >> {addr_q[1:0], 3'b000};
    case (acc_q)
      ACC_BYTE: rd_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      ACC_HALF: rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default:  rd_ext = rd_shift;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // The timeout fires on the last permitted cycle without ack.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  // Count consecutive un-acked cycles spent in S_BUS; zero outside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 16'd0;
    end else if (state != S_BUS) begin
      wait_cnt <= 16'd0;
    end else if (!bus_ack) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // An ack on the limit cycle takes priority over the timeout.
  assign timeout = (state == S_BUS) && !bus_ack && (wait_cnt == LAST_WAIT);
`else
  assign timeout = 1'b0;
`endif

  // Request capture and the IDLE -> BUS/RESP -> IDLE sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      acc_q    <= 2'd0;
      uns_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wr_data;
            wr_q     <= req_wr_ena;
            acc_q    <= req_access;
            uns_q    <= req_unsigned;
            exc_q    <= req_exc;
            result_q <= 32'd0;
            state    <= (req_exc != 3'b000) ? S_RESP : S_BUS;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            result_q <= wr_q ? 32'd0 : rd_ext;
            exc_q    <= 3'b000;
            state    <= S_RESP;
          end else if (timeout) begin
            result_q <= 32'd0;
            exc_q    <= 3'b100;
            state    <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte lanes for the held request; all zero when no bus access is open.
  always_comb begin
    bus_byte_ena = 4'b0000;
    if (bus_req) begin
      case (acc_q)
        ACC_BYTE: bus_byte_ena = 4'b0001 << addr_q[1:0];
        ACC_HALF: bus_byte_ena = 4'b0011 << addr_q[1:0];
        default:  bus_byte_ena = 4'b1111;
      endcase
    end
  end

  // All outputs decode from registered state, so there is no path from the
  // request inputs to the bus, and an async reset clears them at once.
  assign req_ready      = (state == S_IDLE);
  assign resp_valid     = (state == S_RESP);
  assign resp_rd_data   = resp_valid ? result_q : 32'd0;
  assign resp_exception = resp_valid ? exc_q : 3'b000;
  assign bus_req        = (state == S_BUS);
  assign bus_addr       = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wr_ena     = bus_req & wr_q;
  assign bus_wr_data    = bus_req ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vectors, randomized accesses checked against
// a byte-lane reference model, plus reset-in-flight and timeout sequences.
module tb_mem_access_unit;

  localparam logic [15:0] TB_VALID_BANKS = 16'h0007;
  localparam int          TB_TIMEOUT     = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;
  logic        req_wr_ena;
  logic [1:0]  req_access;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rd_data;
  logic [2:0]  resp_exception;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_wr_ena;
  logic [3:0]  bus_byte_ena;
  logic [31:0] bus_wr_data;
  logic        bus_ack;
  logic [31:0] bus_rd_data;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {exception mask, read data}.
  logic [34:0] exp_q[$];

  mem_access_unit #(
    .VALID_BANKS    (TB_VALID_BANKS),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wr_data    (req_wr_data),
    .req_wr_ena     (req_wr_ena),
    .req_access     (req_access),
    .req_unsigned   (req_unsigned),
    .resp_valid     (resp_valid),
    .resp_rd_data   (resp_rd_data),
    .resp_exception (resp_exception),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_wr_ena     (bus_wr_ena),
    .bus_byte_ena   (bus_byte_ena),
    .bus_wr_data    (bus_wr_data),
    .bus_ack        (bus_ack),
    .bus_rd_data    (bus_rd_data),
    .state_dbg      (state_dbg)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run goes astray.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},      req_ready,      32'd1);
    chk({tag, "_bus_req"},        bus_req,        32'd0);
    chk({tag, "_bus_addr"},       bus_addr,       32'd0);
    chk({tag, "_bus_wr_ena"},     bus_wr_ena,     32'd0);
    chk({tag, "_bus_byte_ena"},   bus_byte_ena,   32'd0);
    chk({tag, "_bus_wr_data"},    bus_wr_data,    32'd0);
    chk({tag, "_resp_valid"},     resp_valid,     32'd0);
    chk({tag, "_resp_rd_data"},   resp_rd_data,   32'd0);
    chk({tag, "_resp_exception"}, resp_exception, 32'd0);
  endtask

  // Compare the response cycle against the oldest scoreboard entry.
  task automatic check_resp();
    logic [34:0] e;
    chk("resp_valid", resp_valid, 32'd1);
    chk("ready_in_resp", req_ready, 32'd0);
    chk("bus_req_in_resp", bus_req, 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=response expected=none");
    end else begin
      e = exp_q.pop_front();
      chk("resp_exception", resp_exception, {29'd0, e[34:32]});
      chk("resp_rd_data", resp_rd_data, e[31:0]);
    end
  endtask

  // Reference model: works in byte lanes and plain integer arithmetic.
  function automatic void ref_model(
    input  logic [31:0] a, wd, input logic wr, input logic [1:0] acc,
    input  logic uns, input logic [31:0] bw,
    output logic [2:0] m, output logic [3:0] be,
    output logic [31:0] ewd, output logic [31:0] rd);
    int size, off, bank;
    longint v;
    size = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    bank = int'(a[31:28]);
    m = 3'b000;
    if ((off % size) != 0)          m[0] = 1'b1;
    if (TB_VALID_BANKS[bank] == 0) m[1] = 1'b1;
    be  = 4'b0000;
    ewd = 32'd0;
    for (int i = 0; i < 4; i++)
      if (i >= off) ewd[8*i +: 8] = wd[8*(i-off) +: 8];
    rd = 32'd0;
    if (m == 3'b000) begin
      for (int i = 0; i < size; i++) be[off+i] = 1'b1;
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(bw[8*(off+i) +: 8]) << (8*i));
      if (!uns && size < 4 && v >= (64'sd1 << (8*size-1))) v = v - (64'sd1 << (8*size));
      if (!wr) rd = v[31:0];
    end
  endfunction

  // Drive one request (ready is checked in the cycle it is raised) and run
  // the bus side, acknowledging in cycle ack_cyc after acceptance.
  task automatic do_access(
    input logic [31:0] a, wd, input logic wr, input logic [1:0] acc,
    input logic uns, input int ack_cyc, input logic [31:0] bw,
    input logic [2:0] e_mask, input logic [3:0] e_be,
    input logic [31:0] e_wd, input logic [31:0] e_rd);
    @(negedge clk);
    chk("ready_before_req", req_ready, 32'd1);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wr_data  = wd;
    req_wr_ena   = wr;
    req_access   = acc;
    req_unsigned = uns;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom();
    req_wr_data  = $urandom();
    req_wr_ena   = 1'($urandom_range(0, 1));
    req_access   = 2'($urandom_range(0, 2));
    req_unsigned = 1'($urandom_range(0, 1));
    exp_q.push_back({e_mask, e_rd});
    if (e_mask != 3'b000) begin
      @(negedge clk);
      check_resp();
    end else begin
      for (int c = 1; c <= ack_cyc; c++) begin
        @(negedge clk);
        chk("bus_req_held", bus_req, 32'd1);
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_byte_ena", bus_byte_ena, {28'd0, e_be});
        chk("bus_wr_data", bus_wr_data, e_wd);
        chk("bus_wr_ena", bus_wr_ena, {31'd0, wr});
        chk("resp_valid_during_bus", resp_valid, 32'd0);
        chk("rd_data_during_bus", resp_rd_data, 32'd0);
        chk("ready_during_bus", req_ready, 32'd0);
        if (c == ack_cyc) begin
          bus_ack     = 1'b1;
          bus_rd_data = bw;
        end
        @(posedge clk);
        #1;
        bus_ack     = 1'b0;
        bus_rd_data = $urandom();
      end
      @(negedge clk);
      check_resp();
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  acc;
    logic        uns;
    int          ack;
    logic [31:0] bw;
    logic [2:0]  mask;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] a, wd, bw, ewd, rd;
    logic [3:0]  be;
    logic [2:0]  m;
    logic [1:0]  acc;
    logic        wr, uns;

    rst          = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'd0;
    req_wr_data  = 32'd0;
    req_wr_ena   = 1'b0;
    req_access   = 2'd0;
    req_unsigned = 1'b0;
    bus_ack      = 1'b0;
    bus_rd_data  = 32'd0;

    //            addr          wdata         wr    acc   uns   ack  bus word      mask    be       bus wdata     rd
    vecs[0]  = '{32'h0000_0010, 32'h0,        1'b0, 2'd2, 1'b0, 3, 32'hDEAD_BEEF, 3'b000, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0013, 32'h0,        1'b0, 2'd0, 1'b0, 1, 32'h8000_0000, 3'b000, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{32'h0000_0013, 32'h0,        1'b0, 2'd0, 1'b1, 2, 32'h8000_0000, 3'b000, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{32'h1000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 2, 32'hFFFF_FFFF, 3'b000, 4'b1100, 32'hABCD_0000, 32'h0};
    vecs[4]  = '{32'hF000_0001, 32'h0,        1'b0, 2'd2, 1'b0, 1, 32'h0,         3'b011, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{32'h0000_0001, 32'h0,        1'b0, 2'd1, 1'b0, 1, 32'h0,         3'b001, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{32'h3000_0000, 32'h0,        1'b0, 2'd0, 1'b0, 1, 32'h0,         3'b010, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{32'h2000_0002, 32'h0,        1'b0, 2'd1, 1'b0, 1, 32'h7FFF_8001, 3'b000, 4'b1100, 32'h0,        32'h0000_7FFF};
    vecs[8]  = '{32'h0000_0000, 32'h0,        1'b0, 2'd1, 1'b0, 4, 32'h1234_8001, 3'b000, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[9]  = '{32'h0000_0001, 32'hFFFF_FFA5, 1'b1, 2'd0, 1'b0, 1, 32'h5555_5555, 3'b000, 4'b0010, 32'hFFFF_A500, 32'h0};
    vecs[10] = '{32'h0000_0004, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 1, 32'h1111_1111, 3'b000, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{32'h1000_0002, 32'h0,        1'b0, 2'd1, 1'b1, 1, 32'h9ABC_0000, 3'b000, 4'b1100, 32'h0,        32'h0000_9ABC};
    vecs[12] = '{32'h8000_0000, 32'h1,        1'b1, 2'd2, 1'b0, 1, 32'h0,         3'b010, 4'b0000, 32'h0,        32'h0};

    // Reset state, then release away from the active edge.
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fixed vectors.
    for (int i = 0; i < 13; i++)
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].acc, vecs[i].uns,
                vecs[i].ack, vecs[i].bw, vecs[i].mask, vecs[i].be, vecs[i].ewd, vecs[i].rd);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      a   = {4'($urandom_range(0, 4)), 26'($urandom()), 2'($urandom_range(0, 3))};
      wd  = $urandom();
      wr  = 1'($urandom_range(0, 1));
      acc = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      bw  = $urandom();
      ref_model(a, wd, wr, acc, uns, bw, m, be, ewd, rd);
      do_access(a, wd, wr, acc, uns, $urandom_range(1, 5), bw, m, be, ewd, rd);
    end

    // Reset pulsed while the bus access is open.
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = 32'h0000_0020;
    req_wr_data = 32'h0;
    req_wr_ena  = 1'b0;
    req_access  = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_reset_bus_open", bus_req, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    bus_ack     = 1'b1;
    bus_rd_data = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stale_ack_no_resp", resp_valid, 32'd0);
      chk("stale_ack_no_bus", bus_req, 32'd0);
    end
    do_access(32'h0000_0024, 32'h0, 1'b0, 2'd2, 1'b0, 2, 32'h2468_ACE0,
              3'b000, 4'b1111, 32'h0, 32'h2468_ACE0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Ack on the last permitted cycle completes normally.
    do_access(32'h0000_0010, 32'h0, 1'b0, 2'd2, 1'b0, TB_TIMEOUT, 32'hA5A5_5A5A,
              3'b000, 4'b1111, 32'h0, 32'hA5A5_5A5A);
    // No ack at all: bus_req is held for TB_TIMEOUT cycles, then a timeout.
    @(negedge clk);
    chk("ready_before_timeout", req_ready, 32'd1);
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0010;
    req_wr_ena = 1'b0;
    req_access = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back({3'b100, 32'd0});
    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      @(negedge clk);
      chk("timeout_bus_held", bus_req, 32'd1);
    end
    @(negedge clk);
    check_resp();
`endif

    @(negedge clk);
    chk("final_ready", req_ready, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bridge between the multicycle core's data/instruction memory port and the banked system memory bus. It accepts one request at a time from the core with a valid/ready handshake and checks alignment and bank mapping. It drives a word-aligned, byte-enabled request on the variable-latency bus, waits for the acknowledge, then returns lane-aligned, optionally sign-extended read data together with an exception mask.

## Interface
- `VALID_BANKS`, default 16'h0007: bit n set means bank n (addr[31:28]) is mapped.
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles to wait for `bus_ack`. Must be ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: the unit can accept a request.
- `req_addr` in 32: byte address.
- `req_wr_data` in 32: store data, right-justified.
- `req_wr_ena` in 1: 1 = store, 0 = load.
- `req_access` in 2 (`mem_access_t`): byte, half or word.
- `req_unsigned` in 1: zero-extend loads when 1.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rd_data` out 32: load result; 0 for stores and errors.
- `resp_exception` out 3: [0] misaligned, [1] unmapped bank, [2] bus timeout.
- `bus_req` out 1: bus request; held until ack.
- `bus_addr` out 32: {req_addr[31:2], 2'b00}.
- `bus_wr_ena` out 1: bus write.
- `bus_byte_ena` out 4: active byte lanes.
- `bus_wr_data` out 32: store data shifted to its lane.
- `bus_ack` in 1: bus completion, single cycle.
- `bus_rd_data` in 32: read word, valid when `bus_ack` is high.

## Operation
- State machine with three states: S_IDLE, S_BUS, S_RESP.
- S_IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register the address, data, write flag, access type and unsigned flag.
  - Compute the exception mask from the live inputs.
  - If the mask is nonzero, go to S_RESP. Otherwise go to S_BUS.
- Exception checks:
  - Misaligned: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - Unmapped: `VALID_BANKS[addr[31:28]]` = 0.
  - Both bits may be set together.
  - A request with any exception never asserts `bus_req`.
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: 4'b0011 << addr[1:0].
  - Word access: 4'b1111.
- `bus_wr_data` = `req_wr_data` << (8·addr[1:0]).
- S_BUS:
  - `bus_req` = 1, with all bus outputs held constant.
  - On `bus_ack`, capture `bus_rd_data` >> (8·addr[1:0]).
  - Extend the captured data to 32 bits from bit 7 (byte) or bit 15 (half). Sign-extend unless `req_unsigned` = 1, in which case zero-extend.
  - Then go to S_RESP.
  - For stores, `bus_rd_data` is ignored and the result is 0.
- S_RESP:
  - `resp_valid` = 1 for exactly one cycle.
  - `resp_rd_data` and `resp_exception` are valid in that cycle only and 0 in every other cycle.
  - Return to S_IDLE.
- `req_ready` is 0 in S_BUS and S_RESP.
- A `req_valid` that arrives while `req_ready` is low is not accepted. The core must hold it until accepted.

## Timing
- Reset values: state = S_IDLE, `req_ready` = 1, and every other output = 0. This includes `bus_req`, `bus_byte_ena`, `resp_valid`, `resp_rd_data` and `resp_exception`.
- Reset asserted mid-transaction, at any state:
  - Outputs return to their reset values immediately.
  - The in-flight request is dropped, with no response.
  - A later `bus_ack` arriving in S_IDLE is ignored.
- Normal access, with the request accepted at edge 0:
  - `bus_req` is high from cycle 1.
  - `bus_ack` arrives in cycle k (k ≥ 1).
  - `resp_valid` is high in cycle k+1.
  - `req_ready` is high again in cycle k+2.
  - Minimum accept-to-response latency is 2 cycles.
- Error access: `resp_valid` is high in cycle 1, and `req_ready` is high in cycle 2.
- Back-to-back: a new request can be accepted in the first cycle `req_ready` is high. There is no combinational path from `req_valid` to `bus_req`.
- `bus_ack` arriving in the same cycle `bus_req` first rises is legal and completes that cycle.
- `bus_ack` outside S_BUS is ignored.

## Configuration
- Macro: `MEM_ACCESS_TIMEOUT_EN`.
- When defined:
  - A wait counter clears on entry to S_BUS and increments on each cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES` without ack, drop `bus_req`, set `resp_exception`[2], force `resp_rd_data` to 0 and go to S_RESP.
  - An ack in the same cycle the limit is reached wins: no timeout is flagged.
- When undefined: no counter is built, S_BUS waits indefinitely, and `resp_exception`[2] is tied to 0.

## Test plan
- Word load at 0x0000_0010, bus returning 0xDEAD_BEEF with ack after 3 cycles:
  - `bus_addr` = 0x10 and `bus_byte_ena` = 4'hF.
  - `resp_rd_data` = 0xDEAD_BEEF, mask 0.
  - `resp_valid` in cycle 4.
- Signed byte load at 0x0000_0013 with bus data 0x8000_0000 → `resp_rd_data` = 0xFFFF_FF80. The same access with `req_unsigned` = 1 → 0x0000_0080.
- Half store of 0x1234_ABCD at 0x1000_0002:
  - `bus_byte_ena` = 4'b1100, `bus_wr_data` = 0xABCD_0000.
  - `resp_rd_data` = 0.
- Word access at 0xF000_0001:
  - `resp_exception` = 3'b011 in cycle 1.
  - `bus_req` never rises.
- With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16 and no ack:
  - `bus_req` drops.
  - `resp_exception` = 3'b100 in cycle 17.
  - An ack held back to exactly cycle 16 gives mask 0.
- Reset (`rst` = 0) pulsed while in S_BUS → all outputs return to reset values asynchronously. A following ack produces no `resp_valid`, and the next request completes normally.
